// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: next-PC selects,
// FSM state encoding, default reset PC and the branch offset helper.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Next-PC select codes driven by the control decoder
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_J   = 2'b01;
    localparam logic [1:0] NPC_JR  = 2'b10;
    localparam logic [1:0] NPC_BEQ = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ERR   = 3'd4
    } fetch_state_t;

    // Sign-extended, word-scaled beq displacement
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// Combinational next-PC calculation for seq, j/jal, jr and beq, plus a
// flag telling the fetch FSM that the chosen target is not word aligned.
module npc_calc
    import ifu_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [1:0]  s_npc,
    input  logic        zero,
    input  logic [31:0] rs_data,
    output logic [31:0] npc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    // The opcode field does not influence the target; it is folded away here.
    logic unused_opcode;
    assign unused_opcode = ^instr[31:26];

    assign pc_plus4 = pc + 32'd4;

    // Select the target; all arithmetic wraps modulo 2^32
    always_comb begin
        npc = pc_plus4;
        case (s_npc)
            NPC_SEQ: npc = pc_plus4;
            NPC_J:   npc = {pc_plus4[31:28], instr[25:0], 2'b00};
            NPC_JR:  npc = rs_data;
            NPC_BEQ: npc = zero ? (pc_plus4 + branch_offset(instr[15:0])) : pc_plus4;
            default: npc = pc_plus4;
        endcase
    end

    assign misaligned = (npc[1:0] != 2'b00);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one word at a time over a
// req/ready/rvalid handshake, holds it for the decoder until commit, counts
// retired instructions and traps on misaligned branch/jump targets.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       s_npc,
    input  logic             zero,
    input  logic [31:0]      rs_data,
    input  logic             commit,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             addr_err,
    output logic [CNT_W-1:0] retired
);

    fetch_state_t state_q;
    fetch_state_t state_d;

    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] retired_q;

    logic [31:0] npc;
    logic        misaligned;
    logic        load_instr;
    logic        advance;

    npc_calc u_npc_calc (
        .pc         (pc_q),
        .instr      (instr_q),
        .s_npc      (s_npc),
        .zero       (zero),
        .rs_data    (rs_data),
        .npc        (npc),
        .pc_plus4   (pc_plus4),
        .misaligned (misaligned)
    );

    // State register; reset forces IDLE at once, whatever the clock is doing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, handshake outputs and datapath enables
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        addr_err    = 1'b0;
        load_instr  = 1'b0;
        advance     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    load_instr = 1'b1;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (commit) begin
                    if (misaligned) begin
                        state_d = ST_ERR;
                    end else begin
                        advance = 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_ERR: begin
                addr_err = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // PC, held instruction and retire counter; a faulting commit changes none
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= '0;
        end else begin
            if (load_instr) begin
                instr_q <= imem_rdata;
            end
            if (advance) begin
                pc_q      <= npc;
                retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign instr     = instr_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch; inputs change and outputs are
// sampled on the falling clock edge.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic [1:0]  s_npc;
    logic        zero;
    logic [31:0] rs_data;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        addr_err;
    logic [31:0] retired;

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch #(.RESET_PC(32'h0000_3000), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_npc       (s_npc),
        .zero        (zero),
        .rs_data     (rs_data),
        .commit      (commit),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .addr_err    (addr_err),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #20000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    // From FETCH: accept the request, return word one cycle later, end in HOLD
    task automatic fetch_word(input logic [31:0] word);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready  = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
    endtask

    // Pulse commit for one cycle with the given next-PC controls
    task automatic commit_with(input logic [1:0] sel, input logic z, input logic [31:0] rs);
        commit  = 1'b1;
        s_npc   = sel;
        zero    = z;
        rs_data = rs;
        @(negedge clk);
        commit  = 1'b0;
        s_npc   = 2'b00;
        zero    = 1'b0;
        rs_data = 32'd0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (pc !== 32'h0000_3000) begin n_fail++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0000_3000); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid); end
        n_checks++; if (retired !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_retired: got %0d expected 0", retired); end
        n_checks++; if (instr !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_instr: got %h expected 0", instr); end
        n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", addr_err); end
        n_checks++; if (pc_plus4 !== 32'h0000_3004) begin n_fail++; $display("[TB] FAIL reset_pc_plus4: got %h expected %h", pc_plus4, 32'h0000_3004); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL release_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0000_3000) begin n_fail++; $display("[TB] FAIL release_addr: got %h expected %h", imem_addr, 32'h0000_3000); end
    endtask

    task automatic test_sequential;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_wait_req: got %b expected 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL seq_wait_valid: got %b expected 0", instr_valid); end
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2401_0005;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_valid: got %b expected 1", instr_valid); end
        n_checks++; if (instr !== 32'h2401_0005) begin n_fail++; $display("[TB] FAIL seq_instr: got %h expected %h", instr, 32'h2401_0005); end
        n_checks++; if (pc !== 32'h0000_3000) begin n_fail++; $display("[TB] FAIL seq_pc: got %h expected %h", pc, 32'h0000_3000); end
        commit_with(2'b00, 1'b0, 32'd0);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL seq_next_req: got %b expected 1", imem_req); end
        n_checks++; if (imem_addr !== 32'h0000_3004) begin n_fail++; $display("[TB] FAIL seq_next_addr: got %h expected %h", imem_addr, 32'h0000_3004); end
        n_checks++; if (retired !== 32'd1) begin n_fail++; $display("[TB] FAIL seq_retired: got %0d expected 1", retired); end
    endtask

    task automatic test_jump;
        fetch_word(32'h0800_0C10);
        n_checks++; if (pc !== 32'h0000_3004) begin n_fail++; $display("[TB] FAIL jump_pc: got %h expected %h", pc, 32'h0000_3004); end
        n_checks++; if (pc_plus4 !== 32'h0000_3008) begin n_fail++; $display("[TB] FAIL jump_link: got %h expected %h", pc_plus4, 32'h0000_3008); end
        commit_with(2'b01, 1'b0, 32'd0);
        n_checks++; if (imem_addr !== 32'h0000_3040) begin n_fail++; $display("[TB] FAIL jump_addr: got %h expected %h", imem_addr, 32'h0000_3040); end
        n_checks++; if (retired !== 32'd2) begin n_fail++; $display("[TB] FAIL jump_retired: got %0d expected 2", retired); end
    endtask

    task automatic test_branch;
        // jr to 0x3010 to set up the branch
        fetch_word(32'h0200_0008);
        commit_with(2'b10, 1'b0, 32'h0000_3010);
        n_checks++; if (imem_addr !== 32'h0000_3010) begin n_fail++; $display("[TB] FAIL jr_addr: got %h expected %h", imem_addr, 32'h0000_3010); end
        fetch_word(32'h1021_FFFE);
        commit_with(2'b11, 1'b1, 32'd0);
        n_checks++; if (imem_addr !== 32'h0000_300C) begin n_fail++; $display("[TB] FAIL beq_taken: got %h expected %h", imem_addr, 32'h0000_300C); end
        fetch_word(32'h0000_0000);
        commit_with(2'b00, 1'b0, 32'd0);
        fetch_word(32'h1021_FFFE);
        commit_with(2'b11, 1'b0, 32'd0);
        n_checks++; if (imem_addr !== 32'h0000_3014) begin n_fail++; $display("[TB] FAIL beq_not_taken: got %h expected %h", imem_addr, 32'h0000_3014); end
        n_checks++; if (retired !== 32'd6) begin n_fail++; $display("[TB] FAIL branch_retired: got %0d expected 6", retired); end
    endtask

    task automatic test_stall;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            // a stray rvalid during FETCH must not be captured
            imem_rvalid = (i == 1);
            imem_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_req[%0d]: got %b expected 1", i, imem_req); end
            n_checks++; if (imem_addr !== 32'h0000_3014) begin n_fail++; $display("[TB] FAIL stall_addr[%0d]: got %h expected %h", i, imem_addr, 32'h0000_3014); end
        end
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        fetch_word(32'h0060_0008);
        n_checks++; if (instr !== 32'h0060_0008) begin n_fail++; $display("[TB] FAIL stall_instr: got %h expected %h", instr, 32'h0060_0008); end
    endtask

    task automatic test_jr_error;
        commit_with(2'b10, 1'b0, 32'h0000_3002);
        n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_flag: got %b expected 1", addr_err); end
        n_checks++; if (pc !== 32'h0000_3014) begin n_fail++; $display("[TB] FAIL err_pc: got %h expected %h", pc, 32'h0000_3014); end
        n_checks++; if (retired !== 32'd6) begin n_fail++; $display("[TB] FAIL err_retired: got %0d expected 6", retired); end
        commit      = 1'b1;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        repeat (3) @(negedge clk);
        commit      = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL err_req: got %b expected 0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL err_valid: got %b expected 0", instr_valid); end
        n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_sticky: got %b expected 1", addr_err); end
        n_checks++; if (retired !== 32'd6) begin n_fail++; $display("[TB] FAIL err_commit_ignored: got %0d expected 6", retired); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (addr_err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_cleared: got %b expected 0", addr_err); end
        n_checks++; if (pc !== 32'h0000_3000) begin n_fail++; $display("[TB] FAIL err_reset_pc: got %h expected %h", pc, 32'h0000_3000); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL err_restart_req: got %b expected 1", imem_req); end
    endtask

    task automatic test_reset_during_wait;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rwait_valid: got %b expected 0", instr_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stale_valid: got %b expected 0", instr_valid); end
        n_checks++; if (instr !== 32'd0) begin n_fail++; $display("[TB] FAIL stale_instr: got %h expected 0", instr); end
        n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL stale_req: got %b expected 1", imem_req); end
        fetch_word(32'h2401_0005);
        n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL real_valid: got %b expected 1", instr_valid); end
        n_checks++; if (instr !== 32'h2401_0005) begin n_fail++; $display("[TB] FAIL real_instr: got %h expected %h", instr, 32'h2401_0005); end
    endtask

    initial begin
        rst_n       = 1'b1;
        s_npc       = 2'b00;
        zero        = 1'b0;
        rs_data     = 32'd0;
        commit      = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        test_reset();
        test_sequential();
        test_jump();
        test_branch();
        test_stall();
        test_jr_error();
        test_reset_during_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the single-cycle MIPS core; sits directly upstream of the control decoder.
- Holds the PC and fetches one instruction at a time from instruction memory over a req/ready/rvalid handshake.
- Presents the instruction to the decoder and datapath, then computes the next PC on commit from the decoder's s_npc select, the ALU zero flag and rs data.
- Also counts retired instructions and traps misaligned targets.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
s_npc  in  2  next-PC select from decoder: 00 seq, 01 j/jal, 10 jr, 11 beq
zero  in  1  ALU equality flag for beq
rs_data  in  32  register rs value, jr target
commit  in  1  datapath finished current instruction; advance PC
imem_req  out  1  fetch request
imem_addr  out  32  fetch byte address
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid
imem_rdata  in  32  instruction word
instr  out  32  held instruction to decoder
instr_valid  out  1  instr is valid and stable
pc  out  32  address of instr
pc_plus4  out  32  pc+4, link value for jal
addr_err  out  1  sticky misaligned-target flag
retired  out  CNT_W  committed instruction count

Behaviour:
- Reset: clk and rst_n as above; polarity and async behaviour fixed. While rst_n=0, state is IDLE regardless of clock. Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, addr_err=0, retired=0.
- States:
  - IDLE -> FETCH on the first clock after rst_n deasserts.
  - FETCH: imem_req=1, imem_addr=pc. If imem_ready=1, go to WAIT; otherwise hold req and addr stable.
  - WAIT: imem_req=0. On imem_rvalid=1, instr<=imem_rdata and go to HOLD.
  - HOLD: instr_valid=1; instr and pc stable. On commit=1: pc<=npc, retired<=retired+1, go to FETCH, or go to ERR if npc[1:0]!=0.
  - ERR: addr_err=1, imem_req=0, instr_valid=0. Only reset exits ERR.
- Latency: minimum 3 cycles from request to instr_valid with 1-cycle memory (FETCH, WAIT, HOLD). Commit to next imem_req: 1 cycle.
- npc arithmetic (combinational, 32-bit, wraps mod 2^32):
  - 00: pc+4
  - 01: {pc_plus4[31:28], instr[25:0], 2'b00}
  - 10: rs_data
  - 11: zero ? pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}) : pc_plus4
- Ignored inputs:
  - imem_rvalid in IDLE, FETCH, HOLD or ERR is ignored; it is never captured.
  - commit outside HOLD is ignored.
  - rvalid in the same cycle as request acceptance is not allowed; memory latency is at least 1.
- Misalignment: addr_err latches when the computed target has npc[1:0]!=0. pc keeps the faulting instruction's address and retired is not incremented.
- retired wraps from all-ones to 0.
- Reset mid-operation (any state) aborts immediately. An outstanding memory response arriving after reset release is ignored because the unit is in IDLE/FETCH.
- pc_plus4 = pc+4 at all times, including in reset.

Decomposition:
- Shared include (existing include.v): add defines NPC_SEQ=2'b00, NPC_J=2'b01, NPC_JR=2'b10, NPC_BEQ=2'b11, plus FSM state encodings IDLE/FETCH/WAIT/HOLD/ERR; RESET_PC default also defined there.
- One combinational sub-module: npc_calc (inputs pc, instr, s_npc, zero, rs_data; outputs npc, pc_plus4, misaligned). FSM, registers and counter stay in ifu_fetch.

Test Plan:
- Reset: hold rst_n=0 mid-clock -> pc=0x00003000, imem_req=0, instr_valid=0, retired=0 asynchronously; release -> next cycle imem_req=1, imem_addr=0x00003000.
- Sequential: imem_ready=1, rvalid one cycle later with 0x24010005, commit with s_npc=00 -> instr=0x24010005 valid; next imem_addr=0x00003004, retired=1.
- Jump: pc=0x00003004, instr=0x08000C10, s_npc=01, commit -> next imem_addr=0x00003040; jal-style check pc_plus4=0x00003008 during HOLD.
- Branch: pc=0x00003010, instr imm=0xFFFE, s_npc=11. zero=1 -> next pc 0x0000300C. Repeat with zero=0 -> 0x00003014.
- Stall/jr error:
  - imem_ready low 3 cycles -> req and addr held, then accepted.
  - jr with rs_data=0x00003002 -> addr_err=1, ERR state, no further req, commit ignored, retired unchanged.
  - rst_n pulse -> cleared.
- Reset during WAIT: assert rst_n=0 while awaiting rvalid, release, then drive a stale rvalid with 0xDEADBEEF during FETCH -> not captured; instr_valid stays 0 until the real response.
